// File: rtl/pins_pkg.sv
// Shared types, widths and the friction helper for the pin physics sequencer.
package pins_pkg;

    localparam int unsigned NUM_PINS = 10;
    localparam int unsigned PX_W     = 11;
    localparam int unsigned PY_W     = 10;
    localparam int unsigned VEL_W    = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned DIV_W    = 8;

    typedef logic signed [15:0] vel_t;
    typedef logic [10:0]        px_t;
    typedef logic [9:0]         py_t;

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE} seq_state_t;

    // Pull a velocity component toward zero by f without crossing zero.
    function automatic vel_t apply_friction(input vel_t v, input vel_t f);
        vel_t r;
        if (v > f) begin
            r = v - f;
        end else if (v < -f) begin
            r = v + f;
        end else begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/pin_hit_check.sv
// Combinational square hit-box test between the ball and one pin.
module pin_hit_check
    import pins_pkg::*;
#(
    parameter int unsigned HIT_RADIUS = 16
) (
    input  logic [PX_W-1:0] ball_x_i,
    input  logic [PY_W-1:0] ball_y_i,
    input  logic [PX_W-1:0] pin_x_i,
    input  logic [PY_W-1:0] pin_y_i,
    output logic            hit_c_o
);

    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic        [11:0] adx;
    logic        [11:0] ady;

    always_comb begin
        dx      = $signed({1'b0, ball_x_i}) - $signed({1'b0, pin_x_i});
        dy      = $signed({2'b0, ball_y_i}) - $signed({2'b0, pin_y_i});
        adx     = dx[11] ? 12'(-dx) : 12'(dx);
        ady     = dy[11] ? 12'(-dy) : 12'(dy);
        hit_c_o = (adx < 12'(HIT_RADIUS)) && (ady < 12'(HIT_RADIUS));
    end

endmodule

// File: rtl/pin_physics_sequencer.sv
// Per-frame scheduler: scans all pins through one shared hit checker, updates
// sticky hits and velocities, then pulses valid_out once per physics step.
module pin_physics_sequencer
    import pins_pkg::*;
#(
    parameter int unsigned HIT_RADIUS    = 16,
    parameter int unsigned FRICTION      = 2,
    parameter int unsigned STEP_DIV      = 1,
    parameter int unsigned SCREEN_WIDTH  = 1024,
    parameter int unsigned SCREEN_HEIGHT = 768
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          frame_in,
    input  logic          clear_in,
    input  logic [10:0]   ball_x_in,
    input  logic [9:0]    ball_y_in,
    input  logic [15:0]   ball_vx_in,
    input  logic [15:0]   ball_vy_in,
    input  logic [109:0]  pins_x_in,
    input  logic [99:0]   pins_y_in,
    output logic          valid_out,
    output logic [9:0]    pins_hit_out,
    output logic [159:0]  pins_vx_out,
    output logic [159:0]  pins_vy_out,
    output logic [3:0]    knocked_out,
    output logic          busy_out,
    output logic          overrun_out
);

    localparam vel_t FRIC = vel_t'(FRICTION);

    seq_state_t           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 clr_pend_q, clr_pend_d;
    px_t                  bx_q, bx_d;
    py_t                  by_q, by_d;
    vel_t                 bvx_q, bvx_d, bvy_q, bvy_d;
    logic [NUM_PINS-1:0]  hit_q, hit_d;
    vel_t                 vx_q [NUM_PINS];
    vel_t                 vx_d [NUM_PINS];
    vel_t                 vy_q [NUM_PINS];
    vel_t                 vy_d [NUM_PINS];
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic [3:0]           knocked_q, knocked_d;

    px_t                  pin_x [NUM_PINS];
    py_t                  pin_y [NUM_PINS];
    logic                 hit_sel_c;
    logic [3:0]           down_cnt_c;

    for (genvar g = 0; g < int'(NUM_PINS); g++) begin : g_pin
        assign pin_x[g] = pins_x_in[g*PX_W +: PX_W];
        assign pin_y[g] = pins_y_in[g*PY_W +: PY_W];
        assign pins_vx_out[g*VEL_W +: VEL_W] = vx_q[g];
        assign pins_vy_out[g*VEL_W +: VEL_W] = vy_q[g];
    end

    pin_hit_check #(
        .HIT_RADIUS (HIT_RADIUS)
    ) u_hit_check (
        .ball_x_i (bx_q),
        .ball_y_i (by_q),
        .pin_x_i  (pin_x[idx_q]),
        .pin_y_i  (pin_y[idx_q]),
        .hit_c_o  (hit_sel_c)
    );

    // Pins down: already hit or pushed off the visible screen.
    always_comb begin
        down_cnt_c = '0;
        for (int i = 0; i < int'(NUM_PINS); i++) begin
            if (hit_q[i] || (pin_x[i] >= 11'(SCREEN_WIDTH)) || (pin_y[i] >= 10'(SCREEN_HEIGHT))) begin
                down_cnt_c = down_cnt_c + 4'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        div_d      = div_q;
        clr_pend_d = clr_pend_q;
        bx_d       = bx_q;
        by_d       = by_q;
        bvx_d      = bvx_q;
        bvy_d      = bvy_q;
        hit_d      = hit_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        valid_d    = 1'b0;
        overrun_d  = overrun_q;
        knocked_d  = knocked_q;

        case (state_q)
            IDLE: begin
                // A clear (live or deferred) wins over a same-cycle frame.
                if (clear_in || clr_pend_q) begin
                    hit_d      = '0;
                    vx_d       = '{default: '0};
                    vy_d       = '{default: '0};
                    knocked_d  = '0;
                    div_d      = '0;
                    clr_pend_d = 1'b0;
                end else if (frame_in) begin
                    if (div_q == DIV_W'(STEP_DIV - 1)) begin
                        div_d   = '0;
                        idx_d   = '0;
                        state_d = SCAN;
                        bx_d    = ball_x_in;
                        by_d    = ball_y_in;
                        bvx_d   = vel_t'(ball_vx_in);
                        bvy_d   = vel_t'(ball_vy_in);
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            SCAN: begin
                if (frame_in) overrun_d  = 1'b1;
                if (clear_in) clr_pend_d = 1'b1;
                if (hit_q[idx_q]) begin
                    vx_d[idx_q] = apply_friction(vx_q[idx_q], FRIC);
                    vy_d[idx_q] = apply_friction(vy_q[idx_q], FRIC);
                end else if (hit_sel_c) begin
                    hit_d[idx_q] = 1'b1;
                    vx_d[idx_q]  = bvx_q >>> 1;
                    vy_d[idx_q]  = bvy_q >>> 1;
                end
                if (idx_q == IDX_W'(NUM_PINS - 1)) begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ISSUE: begin
                if (frame_in) overrun_d  = 1'b1;
                if (clear_in) clr_pend_d = 1'b1;
                knocked_d = down_cnt_c;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            div_q      <= '0;
            clr_pend_q <= 1'b0;
            bx_q       <= '0;
            by_q       <= '0;
            bvx_q      <= '0;
            bvy_q      <= '0;
            hit_q      <= '0;
            vx_q       <= '{default: '0};
            vy_q       <= '{default: '0};
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            knocked_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            div_q      <= div_d;
            clr_pend_q <= clr_pend_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            bvx_q      <= bvx_d;
            bvy_q      <= bvy_d;
            hit_q      <= hit_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            knocked_q  <= knocked_d;
        end
    end

    assign valid_out    = valid_q;
    assign pins_hit_out = hit_q;
    assign knocked_out  = knocked_q;
    assign busy_out     = busy_q;
    assign overrun_out  = overrun_q;

endmodule
